branch_predictor: RTL
=====================

# branch_predictor

Fetch-stage branch target buffer for the five-stage MIPS pipeline. It predicts the direction and target of each fetched PC and produces the `JumpPredict` bit that travels down the pipe to the hazard unit. It is trained by the Execute stage when a branch, j or jr resolves. It also computes the Execute-stage redirect PC on a mispredict and keeps saturating performance counters.

## Interface
Parameters:
- `INDEX_BITS`, default 4: table has 2^INDEX_BITS direct-mapped entries, indexed by PC[INDEX_BITS+1:2].
- `CNT_BITS`, default 16: width of each performance counter.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PCF` in 32: fetch PC.
- `PredictTakenF` out 1: fetch prediction. Pipelined by the datapath as `JumpPredictD`/`JumpPredictE`.
- `PredictTargetF` out 32: predicted next PC when `PredictTakenF`=1, otherwise PCF+4.
- `PCE` in 32: PC of the Execute-stage instruction.
- `BranchE`, `JumpE`, `JumpRE` in 1 each: Execute instruction is a beq/bne/bgtz, j, or jr. All three are 0 for a bubble.
- `PCSrcE` in 1: actual outcome; 1 means taken. Always 1 for j and jr.
- `TargetE` in 32: actual taken target.
- `JumpPredictE` in 1: prediction made for this instruction at fetch.
- `PredTargetE` in 32: target predicted at fetch, as pipelined by the datapath.
- `RedirectE` out 1: Execute mispredict; fetch must load `RedirectPCE`.
- `RedirectPCE` out 32: correct next PC.
- `BrCount` out CNT_BITS: number of resolved control instructions, saturating.
- `MissCount` out CNT_BITS: number of mispredicts, saturating.

## Operation
- Each entry holds `valid`, `tag` = PC[31:INDEX_BITS+2], `target`[31:0] and a 2-bit counter `ctr`.
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational from registered state.
  - `hit` = valid & tag match.
  - `PredictTakenF` = hit & ctr[1].
  - `PredictTargetF` = PredictTakenF ? target : PCF+4.
- A resolve event occurs when `resolve` = BranchE|JumpE|JumpRE.
- `RedirectE` is asserted when resolve is true and either condition holds:
  - the direction was wrong: PCSrcE != JumpPredictE; or
  - the target was wrong: PCSrcE & JumpPredictE & (TargetE != PredTargetE).
- `RedirectPCE` = PCSrcE ? TargetE : PCE+4. It is 0 when there is no resolve event.
- Table training uses the entry selected by PCE, and happens only on a resolve event:
  - Hit, branch: ctr saturating ±1 (taken increments). If taken, target is overwritten with TargetE.
  - Hit, j/jr: ctr is set to 11 and target to TargetE.
  - Miss and taken: the entry is allocated or replaced. valid=1, tag from PCE, target=TargetE, ctr=10 for a branch or 11 for j/jr.
  - Miss and not taken: no write.
- Counters:
  - `BrCount` increments by 1 on each resolve event.
  - `MissCount` increments by 1 on each RedirectE.
  - Both hold at all-ones.
- Reset: all valid=0, all ctr=01, tag/target=0, counters=0. Comb outputs follow: PredictTakenF=0, PredictTargetF=PCF+4, RedirectE=0, RedirectPCE=0.

## Timing
- Lookup has zero latency (combinational in F).
- Training writes at the rising edge that ends the Execute cycle. A lookup in the same cycle, to the same index, sees the old contents; no bypass.
- StallF/StallD do not affect the block: lookup is re-evaluated on the held PCF, and training depends only on E-stage signals.
- Reset asserted during a resolve cycle: reset wins. There is no table or counter write, and the whole state is re-initialised.
- Counter saturation is checked on the registered value. At all-ones an increment is dropped; there is no wrap.
- PCF+4 and PCE+4 are 32-bit and wrap modulo 2^32.

## Structure
- `branch_predictor_pkg` holds:
  - the counter encodings (SNT/WNT/WT/ST) and the reset value WNT;
  - the function computing tag width from INDEX_BITS;
  - the entry record typedef {valid, tag, target, ctr}.
- Sub-module `sat_counter2`: combinational next-state for the 2-bit counter, inputs ctr and taken. It is instantiated once on the update path.
- The table is flop-based (async read), not block RAM.

## Test plan
- After reset, PCF=0x0040_0010 → PredictTakenF=0, PredictTargetF=0x0040_0014, BrCount=MissCount=0.
- Branch at PCE=0x0040_0020, taken, TargetE=0x0040_0080, JumpPredictE=0:
  - RedirectE=1, RedirectPCE=0x0040_0080, MissCount=1.
  - Next cycle PCF=0x0040_0020 → PredictTakenF=1, PredictTargetF=0x0040_0080.
- Same branch resolved not-taken twice with JumpPredictE matching the lookup:
  - first resolve: ctr 10→01, RedirectE=1, RedirectPCE=0x0040_0024;
  - second resolve: ctr 01→00, RedirectE=0;
  - lookup then predicts not-taken.
- jr at 0x0040_0100 predicted taken to 0x0040_0200, actual TargetE=0x0040_0300:
  - RedirectE=1, RedirectPCE=0x0040_0300;
  - entry target becomes 0x0040_0300.
- Alias: PCE=0x0040_0040 taken evicts the entry at 0x0040_0000 (INDEX_BITS=4) → lookup at 0x0040_0000 now misses.
- Force BrCount to all-ones via 2^CNT_BITS resolves; one more resolve keeps it all-ones. Assert rst during a resolve → no table write, all counters 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-stage branch target buffer: counter encodings,
// tag sizing and the table entry record.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET    = WNT;
    localparam int   MAX_TAG_BITS = 30;

    // Tag covers PC[31:INDEX_BITS+2]; the entry field is sized for the
    // smallest legal table and the unused upper bits stay zero.
    function automatic int tagBits(input int indexBits);
        return 30 - indexBits;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [MAX_TAG_BITS-1:0] tag;
        logic [31:0]             target;
        ctr_e                    ctr;
    } entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/Execute-side signal bundle between the datapath (master) and the
// branch predictor (slave); no handshake, every field is sampled each cycle.
interface branch_predictor_if #(
    parameter int CNT_BITS = 16
);
    logic [31:0]         PCF;
    logic                PredictTakenF;
    logic [31:0]         PredictTargetF;

    logic [31:0]         PCE;
    logic                BranchE;
    logic                JumpE;
    logic                JumpRE;
    logic                PCSrcE;
    logic [31:0]         TargetE;
    logic                JumpPredictE;
    logic [31:0]         PredTargetE;
    logic                RedirectE;
    logic [31:0]         RedirectPCE;

    logic [CNT_BITS-1:0] BrCount;
    logic [CNT_BITS-1:0] MissCount;

    modport master (
        output PCF, PCE, BranchE, JumpE, JumpRE, PCSrcE, TargetE,
               JumpPredictE, PredTargetE,
        input  PredictTakenF, PredictTargetF, RedirectE, RedirectPCE,
               BrCount, MissCount
    );

    modport slave (
        input  PCF, PCE, BranchE, JumpE, JumpRE, PCSrcE, TargetE,
               JumpPredictE, PredTargetE,
        output PredictTakenF, PredictTargetF, RedirectE, RedirectPCE,
               BrCount, MissCount
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state of a 2-bit saturating direction counter; purely combinational,
// no backpressure.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e ctrNext
);

    always_comb begin
        ctrNext = ctr;
        case (ctr)
            SNT:     ctrNext = taken ? WNT : SNT;
            WNT:     ctrNext = taken ? WT  : SNT;
            WT:      ctrNext = taken ? ST  : WNT;
            ST:      ctrNext = taken ? ST  : WT;
            default: ctrNext = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB: zero-latency fetch lookup, Execute redirect and training
// written on the edge ending Execute; never stalls, no backpressure.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);

    localparam int     ENTRIES     = 1 << INDEX_BITS;
    localparam int     TAG_BITS    = tagBits(INDEX_BITS);
    localparam entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};

    function automatic logic [MAX_TAG_BITS-1:0] tagOf(input logic [31:0] pc);
        return MAX_TAG_BITS'(pc >> (32 - TAG_BITS));
    endfunction

    entry_t              btb [ENTRIES];
    logic [CNT_BITS-1:0] brCnt;
    logic [CNT_BITS-1:0] missCnt;

    // Fetch lookup
    logic [INDEX_BITS-1:0] fIdx;
    entry_t                fEntry;
    logic                  fHit;
    logic                  predTaken;

    assign fIdx      = bp.PCF[INDEX_BITS+1:2];
    assign fEntry    = btb[fIdx];
    assign fHit      = fEntry.valid && (fEntry.tag == tagOf(bp.PCF));
    assign predTaken = fHit && fEntry.ctr[1];

    assign bp.PredictTakenF  = predTaken;
    assign bp.PredictTargetF = predTaken ? fEntry.target : bp.PCF + 32'd4;

    // Execute resolve and redirect
    logic resolve;
    logic isJump;
    logic dirWrong;
    logic tgtWrong;
    logic redirect;

    assign resolve  = bp.BranchE | bp.JumpE | bp.JumpRE;
    assign isJump   = bp.JumpE | bp.JumpRE;
    assign dirWrong = bp.PCSrcE != bp.JumpPredictE;
    assign tgtWrong = bp.PCSrcE && bp.JumpPredictE && (bp.TargetE != bp.PredTargetE);
    assign redirect = resolve && (dirWrong || tgtWrong);

    assign bp.RedirectE   = redirect;
    assign bp.RedirectPCE = !resolve    ? 32'd0 :
                            bp.PCSrcE   ? bp.TargetE :
                                          bp.PCE + 32'd4;

    // Training path
    logic [INDEX_BITS-1:0] eIdx;
    logic [MAX_TAG_BITS-1:0] eTag;
    entry_t                eEntry;
    logic                  eHit;
    ctr_e                  ctrNext;
    logic                  wrEn;
    entry_t                wrEntry;

    assign eIdx   = bp.PCE[INDEX_BITS+1:2];
    assign eTag   = tagOf(bp.PCE);
    assign eEntry = btb[eIdx];
    assign eHit   = eEntry.valid && (eEntry.tag == eTag);

    sat_counter2 uCtr (
        .ctr     (eEntry.ctr),
        .taken   (bp.PCSrcE),
        .ctrNext (ctrNext)
    );

    always_comb begin
        wrEn    = 1'b0;
        wrEntry = eEntry;
        if (resolve) begin
            if (eHit) begin
                wrEn = 1'b1;
                if (isJump) begin
                    wrEntry.ctr    = ST;
                    wrEntry.target = bp.TargetE;
                end else begin
                    wrEntry.ctr = ctrNext;
                    if (bp.PCSrcE) begin
                        wrEntry.target = bp.TargetE;
                    end
                end
            end else if (bp.PCSrcE) begin
                // Taken miss claims the slot, evicting any alias.
                wrEn           = 1'b1;
                wrEntry.valid  = 1'b1;
                wrEntry.tag    = eTag;
                wrEntry.target = bp.TargetE;
                wrEntry.ctr    = isJump ? ST : WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i] <= ENTRY_RESET;
            end
            brCnt   <= '0;
            missCnt <= '0;
        end else begin
            if (wrEn) begin
                btb[eIdx] <= wrEntry;
            end
            if (resolve && (brCnt != '1)) begin
                brCnt <= brCnt + CNT_BITS'(1);
            end
            if (redirect && (missCnt != '1)) begin
                missCnt <= missCnt + CNT_BITS'(1);
            end
        end
    end

    assign bp.BrCount   = brCnt;
    assign bp.MissCount = missCnt;

endmodule
